// File: rtl/program_loader.sv
// program_loader: receives a framed RISC-V program image over a byte stream,
// writes it word by word into instruction memory and releases the core only
// after the whole image has arrived with a correct checksum.
//
// Frame: 0xA5, N[7:0], N[15:8], 4*N little-endian payload bytes, checksum C,
// where (sum of payload bytes + C) mod 256 must be 0.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   start           begin a load (honoured only in IDLE, DONE or ERR)
//   rx_data/valid   incoming byte stream
//   rx_ready        loader accepts a byte this cycle
//   imem_we/addr/wdata  single-cycle instruction-memory write port
//   core_hold       1 holds the core in reset
//   busy            load in progress
//   done / error    sticky result of the last load
//   err_code        01 length, 10 checksum, 11 timeout, 00 none
module program_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int unsigned TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;
  localparam logic [1:0]  ERR_NONE  = 2'b00;
  localparam logic [1:0]  ERR_LEN   = 2'b01;
  localparam logic [1:0]  ERR_CSUM  = 2'b10;
  localparam logic [1:0]  ERR_TMO   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state, state_d;
  logic [7:0]        len_lo, len_lo_d;
  logic [15:0]       n_words, n_words_d;
  logic [1:0]        byte_cnt, byte_cnt_d;
  logic [15:0]       word_cnt, word_cnt_d;
  logic [23:0]       shift, shift_d;
  logic [7:0]        csum, csum_d;
  logic [TMO_W-1:0]  tmo, tmo_d;

  logic              rx_ready_d, imem_we_d, core_hold_d, busy_d, done_d, error_d;
  logic [ADDR_W-1:0] imem_addr_d;
  logic [31:0]       imem_wdata_d;
  logic [1:0]        err_code_d;

  logic              accept;
  logic              loading;
  logic [15:0]       len_full;
  logic [7:0]        csum_sum;

  assign accept  = rx_valid && rx_ready;
  assign loading = (state inside {S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM});

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state, datapath and registered-output next values
  always_comb begin
    state_d      = state;
    len_lo_d     = len_lo;
    n_words_d    = n_words;
    byte_cnt_d   = byte_cnt;
    word_cnt_d   = word_cnt;
    shift_d      = shift;
    csum_d       = csum;
    tmo_d        = tmo;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    done_d       = done;
    error_d      = error;
    err_code_d   = err_code;
    len_full     = {rx_data, len_lo};
    csum_sum     = csum + rx_data;

    if (accept)       tmo_d = '0;
    else if (loading) tmo_d = tmo + TMO_W'(1);

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d     = S_SYNC;
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_code_d  = ERR_NONE;
          imem_addr_d = '0;
          csum_d      = '0;
          tmo_d       = '0;
          byte_cnt_d  = '0;
          word_cnt_d  = '0;
        end
      end
      S_SYNC: begin
        // Anything other than the sync byte is swallowed while hunting.
        if (accept && rx_data == SYNC_BYTE) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          if (len_full == 16'd0 || {1'b0, len_full} > MAX_WORDS) begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            err_code_d = ERR_LEN;
          end else begin
            n_words_d = len_full;
            state_d   = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_sum;
          byte_cnt_d = byte_cnt + 2'd1;
          // Earlier bytes sit in shift with byte 0 lowest once three are in.
          shift_d    = {rx_data, shift[23:8]};
          if (byte_cnt == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = ADDR_W'(BASE_ADDR + 32'(word_cnt));
            imem_wdata_d = {rx_data, shift};
            word_cnt_d   = word_cnt + 16'd1;
            if (word_cnt == n_words - 16'd1) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (csum_sum == 8'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte watchdog; only fires on a cycle with no acceptance.
    if (loading && !accept && tmo == TMO_W'(TIMEOUT - 1)) begin
      state_d    = S_ERR;
      error_d    = 1'b1;
      err_code_d = ERR_TMO;
    end

    rx_ready_d  = (state_d inside {S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM});
    busy_d      = rx_ready_d;
    core_hold_d = (state_d != S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_lo     <= '0;
      n_words    <= '0;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      shift      <= '0;
      csum       <= '0;
      tmo        <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      len_lo     <= len_lo_d;
      n_words    <= n_words_d;
      byte_cnt   <= byte_cnt_d;
      word_cnt   <= word_cnt_d;
      shift      <= shift_d;
      csum       <= csum_d;
      tmo        <= tmo_d;
      rx_ready   <= rx_ready_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      core_hold  <= core_hold_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      err_code   <= err_code_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized self-checking bench for program_loader.
// Frames are built from random words; expected writes and outcome come from
// the frame contents (word k at BASE_ADDR+k, checksum rule mod 256).
module tb_program_loader;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned BASE_ADDR = 0;
  localparam int unsigned TIMEOUT   = 16;

  logic              clk = 1'b0;
  logic              reset, start, rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready, imem_we, core_hold, busy, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [1:0]        err_code;

  int n_checks = 0;
  int n_pass   = 0;
  bit stuck    = 1'b0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [7:0]        frame_q[$];
  logic [31:0]       exp_words[$];

  // {rx_ready, imem_we, core_hold, busy, done, error, err_code}
  logic [7:0] status;
  assign status = {rx_ready, imem_we, core_hold, busy, done, error, err_code};

  localparam logic [7:0] ST_IDLE = 8'b0010_0000;
  localparam logic [7:0] ST_DONE = 8'b0000_1000;
  localparam logic [7:0] ST_ELEN = 8'b0010_0101;
  localparam logic [7:0] ST_ECS  = 8'b0010_0110;
  localparam logic [7:0] ST_ETMO = 8'b0010_0111;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  // Write monitor
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Reference frame: random words, checksum from the mod-256 rule.
  task automatic build_frame(input int n, input bit bad);
    int unsigned sum;
    logic [31:0] w;
    logic [7:0]  c;
    sum = 0;
    frame_q.delete();
    exp_words.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      exp_words.push_back(w);
      for (int b = 0; b < 4; b++) begin
        frame_q.push_back(w[8*b +: 8]);
        sum += int'(w[8*b +: 8]);
      end
    end
    c = 8'((256 - (sum % 256)) % 256);
    if (bad) c = c + 8'($urandom_range(1, 255));
    frame_q.push_back(c);
  endtask

  function automatic int wr_mismatches();
    int bad = 0;
    int n = (wr_data_q.size() < exp_words.size()) ? wr_data_q.size() : exp_words.size();
    for (int k = 0; k < n; k++)
      if (wr_addr_q[k] !== ADDR_W'(BASE_ADDR + k) || wr_data_q[k] !== exp_words[k]) bad++;
    return bad + ((wr_data_q.size() != exp_words.size()) ? 1 : 0);
  endfunction

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waitc = 0;
    if (stuck) return;
    repeat (gap) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 50) begin
      n_checks++;
      $display("FAIL rx_ready_wait: got rx_ready=%b for 50 cycles, want 1", rx_ready);
      stuck = 1'b1;
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frame_q[i]) send_byte(frame_q[i], $urandom_range(0, max_gap));
  endtask

  task automatic do_start();
    start    = 1'b1;
    rx_valid = 1'($urandom);
    rx_data  = 8'hA5;
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      start    = 1'($urandom);
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    rx_valid = 1'b0;
    n_checks++;
    if (status !== ST_IDLE) $display("FAIL reset_status: got %b want %b", status, ST_IDLE);
    else n_pass++;
    n_checks++;
    if (imem_addr !== '0 || imem_wdata !== 32'd0)
      $display("FAIL reset_bus: got addr=%h data=%h want 0/0", imem_addr, imem_wdata);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (status !== ST_IDLE || wr_data_q.size() != 0)
      $display("FAIL reset_idle: got %b writes=%0d want %b writes=0", status, wr_data_q.size(), ST_IDLE);
    else n_pass++;
  endtask

  task automatic test_nominal(input bit hunt, input bit bad_csum);
    logic [7:0] nom [12];
    logic [7:0] exp_st;
    nom = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB4};
    if (bad_csum) nom[11] = 8'hB5;
    exp_words.delete();
    exp_words.push_back(32'h12345678);
    exp_words.push_back(32'hDEADBEEF);
    clear_mon();
    do_start();
    n_checks++;
    if ({rx_ready, busy, core_hold, done, error} !== 5'b11100)
      $display("FAIL start_loading: got %b want 11100", {rx_ready, busy, core_hold, done, error});
    else n_pass++;
    if (hunt) begin
      send_byte(8'h00, 1);
      send_byte(8'hFF, 0);
      send_byte(8'h5A, 2);
    end
    for (int i = 0; i < 12; i++) send_byte(nom[i], $urandom_range(0, 3));
    exp_st = bad_csum ? ST_ECS : ST_DONE;
    n_checks++;
    if (status !== exp_st) $display("FAIL nominal_status(hunt=%0d bad=%0d): got %b want %b", hunt, bad_csum, status, exp_st);
    else n_pass++;
    n_checks++;
    if (wr_mismatches() != 0)
      $display("FAIL nominal_writes: got %0d writes (%0d bad) want 2 at 0,1", wr_data_q.size(), wr_mismatches());
    else n_pass++;
  endtask

  task automatic test_csum_error();
    test_nominal(1'b0, 1'b1);
    build_frame(3, 1'b0);
    clear_mon();
    do_start();
    send_frame(2);
    n_checks++;
    if (status !== ST_DONE) $display("FAIL csum_recover: got %b want %b", status, ST_DONE);
    else n_pass++;
    n_checks++;
    if (wr_mismatches() != 0) $display("FAIL csum_recover_writes: got %0d bad want 0", wr_mismatches());
    else n_pass++;
  endtask

  task automatic test_length();
    logic [15:0] bad_n [2];
    bad_n = '{16'h0000, 16'h0401};
    for (int i = 0; i < 2; i++) begin
      clear_mon();
      do_start();
      send_byte(8'hA5, 1);
      send_byte(bad_n[i][7:0], 0);
      send_byte(bad_n[i][15:8], 1);
      n_checks++;
      if (status !== ST_ELEN) $display("FAIL len_error(N=%h): got %b want %b", bad_n[i], status, ST_ELEN);
      else n_pass++;
      n_checks++;
      if (wr_data_q.size() != 0) $display("FAIL len_nowrite(N=%h): got %0d writes want 0", bad_n[i], wr_data_q.size());
      else n_pass++;
    end
    build_frame(1024, 1'b0);
    clear_mon();
    do_start();
    send_frame(0);
    n_checks++;
    if (status !== ST_DONE) $display("FAIL len_max: got %b want %b", status, ST_DONE);
    else n_pass++;
    n_checks++;
    if (wr_mismatches() != 0)
      $display("FAIL len_max_writes: got %0d writes (%0d bad) want 1024", wr_data_q.size(), wr_mismatches());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int cyc = 0;
    clear_mon();
    do_start();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 1);
    send_byte(8'h00, 0);
    send_byte(8'h11, 2);
    send_byte(8'h22, 1);
    while (error !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != TIMEOUT) $display("FAIL timeout_latency: got %0d cycles want %0d", cyc, TIMEOUT);
    else n_pass++;
    n_checks++;
    if (status !== ST_ETMO || wr_data_q.size() != 0)
      $display("FAIL timeout_status: got %b writes=%0d want %b writes=0", status, wr_data_q.size(), ST_ETMO);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    build_frame(4, 1'b0);
    clear_mon();
    do_start();
    for (int i = 0; i < 8; i++) send_byte(frame_q[i], $urandom_range(0, 1));
    reset    = 1'b0;
    rx_valid = 1'($urandom);
    rx_data  = 8'($urandom);
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    n_checks++;
    if (status !== ST_IDLE || imem_addr !== '0 || imem_wdata !== 32'd0)
      $display("FAIL reset_mid: got %b addr=%h data=%h want %b 0 0", status, imem_addr, imem_wdata, ST_IDLE);
    else n_pass++;
    build_frame(3, 1'b0);
    clear_mon();
    do_start();
    send_frame(3);
    n_checks++;
    if (status !== ST_DONE || wr_mismatches() != 0)
      $display("FAIL reset_mid_reload: got %b bad=%0d want %b bad=0", status, wr_mismatches(), ST_DONE);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, 8);
      bit bad = ($urandom_range(0, 2) == 0);
      logic [7:0] g;
      logic [7:0] exp_st;
      build_frame(n, bad);
      clear_mon();
      do_start();
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, $urandom_range(0, 2));
      end
      send_frame(3);
      exp_st = bad ? ST_ECS : ST_DONE;
      n_checks++;
      if (status !== exp_st) $display("FAIL random_status(it=%0d n=%0d): got %b want %b", it, n, status, exp_st);
      else n_pass++;
      n_checks++;
      if (wr_mismatches() != 0)
        $display("FAIL random_writes(it=%0d): got %0d writes (%0d bad) want %0d", it, wr_data_q.size(), wr_mismatches(), n);
      else n_pass++;
    end
  endtask

  // Zero-gap frame with start held high: no stalls and no restart.
  task automatic test_back_to_back();
    time t0;
    build_frame(5, 1'b0);
    clear_mon();
    do_start();
    start = 1'b1;
    t0 = $time;
    send_frame(0);
    start = 1'b0;
    n_checks++;
    if (($time - t0) != time'(10 * frame_q.size()))
      $display("FAIL b2b_throughput: got %0t want %0d cycles", $time - t0, frame_q.size());
    else n_pass++;
    n_checks++;
    if (status !== ST_DONE || wr_mismatches() != 0)
      $display("FAIL b2b_result: got %b bad=%0d want %b bad=0", status, wr_mismatches(), ST_DONE);
    else n_pass++;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    test_reset();
    test_nominal(1'b0, 1'b0);
    test_nominal(1'b1, 1'b0);
    test_csum_error();
    test_length();
    test_timeout();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
